// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed lw/sw against a local data
// memory, the MEM/WB latch, and an optional multi-cycle access with an upstream stall.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 7,
    parameter int MEM_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              xm_valid,
    input  logic              xm_mem_read,
    input  logic              xm_mem_write,
    input  logic              xm_reg_write,
    input  logic              xm_mem_to_reg,
    input  logic [DATA_W-1:0] xm_alu_result,
    input  logic [DATA_W-1:0] xm_store_data,
    input  logic [4:0]        xm_rd,
    output logic              mw_valid,
    output logic              mw_reg_write,
    output logic [4:0]        mw_rd,
    output logic [DATA_W-1:0] mw_wb_data,
    output logic              mem_stall,
    output logic              addr_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic {StIdle, StWait} state_e;

    localparam logic [2:0]        CntInit  = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;
    localparam logic [DATA_W-1:0] DepthLim = DATA_W'(DEPTH);

    logic [DATA_W-1:0] DM [DEPTH];

    state_e            r_state;
    state_e            w_state_d;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_d;
    logic              r_valid;
    logic              r_reg_write;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_addr_err;

    logic              w_memop;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic              w_fire;
    logic              w_stall;
    logic              w_access;
    logic              w_store;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_wb_data;

    assign w_memop    = xm_valid & (xm_mem_read | xm_mem_write);
    assign w_in_range = (xm_alu_result < DepthLim);
    assign w_idx      = xm_alu_result[ADDR_W-1:0];

    // Wait-state sequencing: w_fire marks the edge at which MW takes the instruction.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_fire    = 1'b1;
        w_stall   = 1'b0;
        if (MEM_LAT != 0) begin
            case (r_state)
                StIdle: begin
                    if (w_memop) begin
                        w_stall   = 1'b1;
                        w_fire    = 1'b0;
                        w_state_d = StWait;
                        w_cnt_d   = CntInit;
                    end
                end
                StWait: begin
                    if (r_cnt != 3'd0) begin
                        w_stall = 1'b1;
                        w_fire  = 1'b0;
                        w_cnt_d = r_cnt - 3'd1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // A reset cycle must never commit a store, even one aligned with a clock edge.
    assign w_access    = w_fire & w_memop;
    assign w_store     = w_access & xm_mem_write & w_in_range & ~rst;
    assign w_load_data = w_in_range ? DM[w_idx] : '0;
    assign mem_stall   = w_stall & ~rst;

    // Write-back data select; a combined read+write returns the address.
    always_comb begin
        w_wb_data = xm_alu_result;
        if (w_memop && xm_mem_to_reg && !(xm_mem_read && xm_mem_write)) begin
            w_wb_data = w_load_data;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Data memory: not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_store) begin
            DM[w_idx] <= xm_store_data;
        end
    end

    // MEM/WB latch and sticky address error; stall cycles push bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= 5'd0;
            r_wb_data   <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_valid     <= xm_valid;
                r_reg_write <= xm_valid & xm_reg_write;
                r_rd        <= xm_rd;
                r_wb_data   <= w_wb_data;
            end else begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
            end
            if (w_access && !w_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign mw_valid     = r_valid;
    assign mw_reg_write = r_reg_write;
    assign mw_rd        = r_rd;
    assign mw_wb_data   = r_wb_data;
    assign addr_err     = r_addr_err;
    assign dbg_data     = DM[dbg_addr];

endmodule
